// File: rtl/frame_sel_sequencer.sv
// frame_sel_sequencer
// Drives the SEL_W-bit frame select for the seven-segment pattern selector.
// The select steps through frames 0..i_last at a programmable prescaled rate.
// Playback modes are forward wrap, reverse wrap, ping-pong and one-shot
// forward. The block also supports pause with single-step, and restart.
// A one-cycle o_frame_tick accompanies every new o_sel value.
//
// Build option: define FRAME_SEL_STEP_SYNC_EN to pass i_step through a
// 2-flop synchronizer and rising-edge detector. In that build one step is
// taken per button press, with two extra cycles of latency. Without it,
// i_step is a synchronous level and steps once per cycle while high.

module frame_sel_sequencer #(
  parameter int DIV_W = 16,
  parameter int SEL_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic [SEL_W-1:0] i_last,
  input  logic [1:0]       i_mode,
  input  logic             i_step,
  input  logic             i_restart,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_frame_tick,
  output logic             o_done
);

  localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_REV  = 2'b01,
    MODE_PING = 2'b10,
    MODE_ONCE = 2'b11
  } mode_t;

  // Ping-pong sweep direction; this is the only true state machine here.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [DIV_W-1:0] presc_cnt;
  logic [DIV_W-1:0] presc_next;
  logic             presc_term;
  logic             step_event;
  logic             advance;
  mode_t            mode;
  dir_t             dir;
  dir_t             dir_next;
  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] sel_dec;
  logic [SEL_W-1:0] last_dec;
  logic [SEL_W-1:0] sel_next;
  logic             done_next;
  logic             tick_next;

  assign mode     = mode_t'(i_mode);
  assign sel_inc  = o_sel + SEL_ONE;
  assign sel_dec  = o_sel - SEL_ONE;
  assign last_dec = i_last - SEL_ONE;

  // A count above a freshly lowered i_div is treated as terminal, so the
  // prescaler never has to run all the way around its range.
  assign presc_term = (presc_cnt >= i_div);

`ifdef FRAME_SEL_STEP_SYNC_EN
  logic step_meta;
  logic step_sync;
  logic step_prev;

  // Two-flop synchronizer for the asynchronous step button, plus history bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_meta <= 1'b0;
      step_sync <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_meta <= i_step;
      step_sync <= step_meta;
      step_prev <= step_sync;
    end
  end

  assign step_event = step_sync & ~step_prev;
`else
  assign step_event = i_step;
`endif

  // Stepping is only meaningful while paused; auto-play owns the advance.
  assign advance = i_en ? presc_term : step_event;

  // Prescaler next count: cleared by restart, frozen while paused.
  always_comb begin
    presc_next = presc_cnt;
    if (i_restart) begin
      presc_next = DIV_ZERO;
    end else if (i_en) begin
      if (presc_term) begin
        presc_next = DIV_ZERO;
      end else begin
        presc_next = presc_cnt + DIV_ONE;
      end
    end else begin
      presc_next = presc_cnt;
    end
  end

  // Prescaler count register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_cnt <= DIV_ZERO;
    end else begin
      presc_cnt <= presc_next;
    end
  end

  // Next-frame, direction, done and tick decode for the current advance.
  always_comb begin
    sel_next  = o_sel;
    done_next = o_done;
    tick_next = 1'b0;
    dir_next  = dir;
    if (i_restart) begin
      sel_next  = SEL_ZERO;
      done_next = 1'b0;
      dir_next  = DIR_UP;
    end else begin
      // Leaving ping-pong always re-arms the sweep in the upward direction.
      if (mode != MODE_PING) begin
        dir_next = DIR_UP;
      end else begin
        dir_next = dir;
      end
      if (advance) begin
        case (mode)
          MODE_FWD: begin
            tick_next = 1'b1;
            if (o_sel >= i_last) begin
              sel_next = SEL_ZERO;
            end else begin
              sel_next = sel_inc;
            end
          end
          MODE_REV: begin
            tick_next = 1'b1;
            if ((o_sel == SEL_ZERO) || (o_sel > i_last)) begin
              sel_next = i_last;
            end else begin
              sel_next = sel_dec;
            end
          end
          MODE_PING: begin
            tick_next = 1'b1;
            if (dir == DIR_UP) begin
              if (o_sel >= i_last) begin
                // Turn at the top; the endpoint is not repeated.
                dir_next = DIR_DOWN;
                if (i_last == SEL_ZERO) begin
                  sel_next = SEL_ZERO;
                end else begin
                  sel_next = last_dec;
                end
              end else begin
                sel_next = sel_inc;
              end
            end else begin
              if (o_sel == SEL_ZERO) begin
                // Turn at the bottom; a one-frame sequence just stays at 0.
                dir_next = DIR_UP;
                if (i_last != SEL_ZERO) begin
                  sel_next = SEL_ONE;
                end else begin
                  sel_next = SEL_ZERO;
                end
              end else if (o_sel > i_last) begin
                // i_last was lowered under us: come back inside the range.
                sel_next = i_last;
              end else begin
                sel_next = sel_dec;
              end
            end
          end
          MODE_ONCE: begin
            if (!o_done) begin
              tick_next = 1'b1;
              if (o_sel < i_last) begin
                sel_next  = sel_inc;
                done_next = (sel_inc == i_last);
              end else begin
                sel_next  = i_last;
                done_next = 1'b1;
              end
            end else begin
              // Completed one-shot holds silently until restart.
              sel_next  = o_sel;
              tick_next = 1'b0;
            end
          end
          default: begin
            sel_next  = o_sel;
            tick_next = 1'b0;
          end
        endcase
      end else begin
        sel_next  = o_sel;
        tick_next = 1'b0;
      end
    end
  end

  // Ping-pong direction state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dir <= DIR_UP;
    end else begin
      dir <= dir_next;
    end
  end

  // Registered frame select, done flag and frame tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sel        <= SEL_ZERO;
      o_done       <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      o_sel        <= sel_next;
      o_done       <= done_next;
      o_frame_tick <= tick_next;
    end
  end

endmodule
